// File: rtl/fc_result_reader.sv
// fc_result_reader: final stage of the inference chain.
// Captures a packed class-score vector on `start`, scans it one score per cycle
// for the signed maximum, then presents index/score through a valid/ack handshake.
module fc_result_reader #(
    parameter int unsigned N_CLASS = 10,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CLASS*SCORE_W-1:0] data_in,
    output logic                       result_valid,
    input  logic                       result_ack,
    output logic [IDX_W-1:0]           class_idx,
    output logic [SCORE_W-1:0]         class_score,
    output logic                       busy,
    output logic                       overrun,
    output logic [15:0]                img_count
);

    typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_CLASS - 1);

    state_e                     state_q, state_d;
    logic [N_CLASS*SCORE_W-1:0] buf_q, buf_d;
    logic [SCORE_W-1:0]         best_q, best_d;
    logic [IDX_W-1:0]           best_idx_q, best_idx_d;
    logic [IDX_W-1:0]           k_q, k_d;
    logic [IDX_W-1:0]           class_idx_q, class_idx_d;
    logic [SCORE_W-1:0]         class_score_q, class_score_d;
    logic                       valid_q, valid_d;
    logic                       overrun_q, overrun_d;
    logic [15:0]                img_count_q, img_count_d;

    logic [SCORE_W-1:0]         cur_score;
    logic                       cur_gt;

    // Select the score currently addressed by the scan pointer
    always_comb begin
        cur_score = '0;
        for (int unsigned i = 0; i < N_CLASS; i++) begin
            if (k_q == IDX_W'(i)) begin
                cur_score = buf_q[i*SCORE_W +: SCORE_W];
            end
        end
    end

    // Strictly greater so that ties keep the lower index
    assign cur_gt = $signed(cur_score) > $signed(best_q);

    // Next-state logic for the scan FSM and result registers
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        k_d           = k_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        valid_d       = valid_q;
        overrun_d     = overrun_q;
        img_count_d   = img_count_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    buf_d      = data_in;
                    best_d     = data_in[SCORE_W-1:0];
                    best_idx_d = '0;
                    k_d        = IDX_W'(1);
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (cur_gt) begin
                    best_d     = cur_score;
                    best_idx_d = k_q;
                end
                k_d = k_q + IDX_W'(1);
                if (k_q == LastIdx) begin
                    // Publish the best including the score compared this cycle
                    class_idx_d   = cur_gt ? k_q : best_idx_q;
                    class_score_d = cur_gt ? cur_score : best_q;
                    valid_d       = 1'b1;
                    img_count_d   = img_count_q + 16'd1;
                    state_d       = StHold;
                end
                if (start) begin
                    overrun_d = 1'b1;
                end
            end
            StHold: begin
                if (result_ack) begin
                    valid_d = 1'b0;
                    if (start) begin
                        // Ack and new vector in the same cycle: no bubble, no overrun
                        buf_d      = data_in;
                        best_d     = data_in[SCORE_W-1:0];
                        best_idx_d = '0;
                        k_d        = IDX_W'(1);
                        state_d    = StScan;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (start) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            buf_q         <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            k_q           <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            img_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            k_q           <= k_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            img_count_q   <= img_count_d;
        end
    end

    assign result_valid = valid_q;
    assign class_idx    = class_idx_q;
    assign class_score  = class_score_q;
    assign busy         = (state_q != StIdle);
    assign overrun      = overrun_q;
    assign img_count    = img_count_q;

endmodule

// File: tb/tb_fc_result_reader.sv
// Testbench for fc_result_reader: directed vectors, expected results queued
// by the stimulus and checked by an independent monitor on each new result.
module tb_fc_result_reader;

    localparam int NC = 10;
    localparam int SW = 16;
    localparam int IW = 4;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              start;
    logic [NC*SW-1:0]  data_in;
    logic              result_valid;
    logic              result_ack;
    logic [IW-1:0]     class_idx;
    logic [SW-1:0]     class_score;
    logic              busy;
    logic              overrun;
    logic [15:0]       img_count;

    typedef struct {
        logic [IW-1:0] idx;
        logic [SW-1:0] score;
        logic [15:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    exp_t e_new;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;

    logic [SW-1:0]    sv [NC];
    logic [NC*SW-1:0] vec1, vec_neg2, vec_minmax, vec_c, vec_d, vec_b;
    int               n;
    logic             stable;

    fc_result_reader #(
        .N_CLASS(NC),
        .SCORE_W(SW),
        .IDX_W  (IW)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .result_valid(result_valid),
        .result_ack  (result_ack),
        .class_idx   (class_idx),
        .class_score (class_score),
        .busy        (busy),
        .overrun     (overrun),
        .img_count   (img_count)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [NC*SW-1:0] pack(input logic [SW-1:0] s [NC]);
        logic [NC*SW-1:0] v;
        for (int i = 0; i < NC; i++) v[i*SW +: SW] = s[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] idx, input logic [SW-1:0] sc, input logic [15:0] c);
        e_new.idx   = idx;
        e_new.score = sc;
        e_new.cnt   = c;
        exp_q.push_back(e_new);
    endtask

    // Call at a negedge; returns at the negedge after the capturing posedge
    task automatic send(input logic [NC*SW-1:0] v);
        start   = 1'b1;
        data_in = v;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    // Counts negedges until result_valid is seen, bounded
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!result_valid && cnt < 40) begin
            @(negedge clk_in);
            cnt++;
        end
        if (!result_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_valid: got timeout after %0d cycles, expected result_valid", cnt);
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(negedge clk_in);
        result_ack = 1'b0;
    endtask

    // Monitor: compare each newly presented result against the queue head
    always @(negedge clk_in) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (result_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mon_unexpected: got result idx %0d score 0x%0h, expected none",
                             class_idx, class_score);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("mon_idx", 32'(class_idx), 32'(e_mon.idx));
                    check("mon_score", 32'(class_score), 32'(e_mon.score));
                    check("mon_count", 32'(img_count), 32'(e_mon.cnt));
                end
            end
            prev_valid = result_valid;
        end
    end

    initial begin
        sv = '{16'd5, 16'hFFFD, 16'd7, 16'd100, 16'd2, 16'd0, 16'hFFFF, 16'd99, 16'd4, 16'd8};
        vec1 = pack(sv);
        for (int i = 0; i < NC; i++) sv[i] = 16'hFFFE;
        vec_neg2 = pack(sv);
        for (int i = 0; i < NC; i++) sv[i] = 16'h8000;
        sv[9] = 16'h7FFF;
        vec_minmax = pack(sv);
        sv = '{16'd1, 16'd2, 16'd50, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        vec_c = pack(sv);
        sv = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd700, 16'd70, 16'd80, 16'd90};
        vec_d = pack(sv);
        for (int i = 0; i < NC; i++) sv[i] = 16'h7FFF;
        vec_b = pack(sv);

        rst        = 1'b1;
        start      = 1'b0;
        result_ack = 1'b0;
        data_in    = '0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("reset_valid", 32'(result_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_idx", 32'(class_idx), 0);
        check("reset_score", 32'(class_score), 0);
        check("reset_count", 32'(img_count), 0);

        // Basic max search, latency and hold stability
        push(4'd3, 16'd100, 16'd1);
        send(vec1);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_valid_early", 32'(result_valid), 0);
        wait_valid(n);
        check("t1_latency", 32'(n), 9);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (!result_valid || class_idx !== 4'd3 || class_score !== 16'd100) stable = 1'b0;
        end
        check("t1_hold_stable", 32'(stable), 1);
        check("t1_count", 32'(img_count), 1);
        do_ack();
        check("t1_valid_after_ack", 32'(result_valid), 0);
        check("t1_busy_after_ack", 32'(busy), 0);
        check("t1_idx_retained", 32'(class_idx), 3);
        // Ack with no result pending is ignored
        result_ack = 1'b1;
        repeat (2) @(negedge clk_in);
        result_ack = 1'b0;
        check("stray_ack_valid", 32'(result_valid), 0);
        check("stray_ack_count", 32'(img_count), 1);

        // Ties keep index 0; signed extremes
        push(4'd0, 16'hFFFE, 16'd2);
        send(vec_neg2);
        wait_valid(n);
        do_ack();
        push(4'd9, 16'h7FFF, 16'd3);
        send(vec_minmax);
        wait_valid(n);
        do_ack();

        // Start coinciding with ack in HOLD
        push(4'd2, 16'd50, 16'd4);
        send(vec_c);
        wait_valid(n);
        push(4'd6, 16'd700, 16'd5);
        result_ack = 1'b1;
        send(vec_d);
        result_ack = 1'b0;
        check("t5_valid_cleared", 32'(result_valid), 0);
        check("t5_busy_kept", 32'(busy), 1);
        check("t5_no_overrun", 32'(overrun), 0);
        wait_valid(n);
        check("t5_latency", 32'(n), 9);
        do_ack();

        // Dropped start during SCAN
        push(4'd3, 16'd100, 16'd6);
        send(vec1);
        repeat (3) @(negedge clk_in);
        check("t4_overrun_before", 32'(overrun), 0);
        send(vec_b);
        check("t4_overrun_set", 32'(overrun), 1);
        wait_valid(n);
        do_ack();
        repeat (15) @(negedge clk_in);
        check("t4_no_extra_valid", 32'(result_valid), 0);
        check("t4_count", 32'(img_count), 6);
        check("t4_overrun_sticky", 32'(overrun), 1);

        // Reset mid-SCAN
        send(vec1);
        repeat (4) @(negedge clk_in);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(result_valid), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_overrun", 32'(overrun), 0);
        check("t6_rst_idx", 32'(class_idx), 0);
        check("t6_rst_score", 32'(class_score), 0);
        check("t6_rst_count", 32'(img_count), 0);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("t6_idle_after_rst", 32'(busy), 0);
        push(4'd3, 16'd100, 16'd1);
        send(vec1);
        wait_valid(n);
        do_ack();
        check("t6_count", 32'(img_count), 1);

        // Counter wrap with ack tied high; preload the counter near the top
        @(negedge clk_in);
        force dut.img_count_q = 16'hFFFD;
        @(negedge clk_in);
        release dut.img_count_q;
        @(negedge clk_in);
        check("t7_preload", 32'(img_count), 32'hFFFD);
        result_ack = 1'b1;
        push(4'd3, 16'd100, 16'hFFFE);
        send(vec1);
        wait_valid(n);
        push(4'd2, 16'd50, 16'hFFFF);
        send(vec_c);
        check("t7_pulse1", 32'(result_valid), 0);
        check("t7_busy1", 32'(busy), 1);
        wait_valid(n);
        check("t7_spacing", 32'(n), 9);
        push(4'd6, 16'd700, 16'h0000);
        send(vec_d);
        check("t7_pulse2", 32'(result_valid), 0);
        wait_valid(n);
        @(negedge clk_in);
        check("t7_pulse3", 32'(result_valid), 0);
        check("t7_idle", 32'(busy), 0);
        check("t7_wrapped", 32'(img_count), 0);
        result_ack = 1'b0;

        repeat (2) @(negedge clk_in);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
